// File: rtl/team_06_wb_pkg.sv
// Shared types and constants for the Wishbone SRAM responder slice.
package team_06_wb_pkg;

    localparam int WB_ADDR_W = 32;
    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;

    localparam logic [WB_ADDR_W-1:0] WB_DEFAULT_BASE = 32'h3300_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2,
        TURN = 2'd3
    } wb_resp_state_t;

    // Replace the byte lanes of old_w selected by sel with those of new_w.
    function automatic logic [WB_DATA_W-1:0] lane_merge(
        input logic [WB_DATA_W-1:0] old_w,
        input logic [WB_DATA_W-1:0] new_w,
        input logic [WB_SEL_W-1:0]  sel
    );
        logic [WB_DATA_W-1:0] res;
        res = old_w;
        for (int b = 0; b < WB_SEL_W; b++) begin
            if (sel[b]) begin
                res[8*b +: 8] = new_w[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_w[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/team_06_wb_mem_bank.sv
// Single-port word memory with byte-lane writes and a registered, enable-gated read port.
module team_06_wb_mem_bank
    import team_06_wb_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_W-1:0]     idx_i,
    input  logic                 we_i,
    input  logic                 re_i,
    input  logic [WB_SEL_W-1:0]  sel_i,
    input  logic [WB_DATA_W-1:0] wdata_i,
    output logic [WB_DATA_W-1:0] rdata_o
);

    logic [WB_DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [WB_DATA_W-1:0] rdata_q;

    // Array storage: contents survive reset, only selected lanes are written.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= lane_merge(mem_q[idx_i], wdata_i, sel_i);
        end
    end

    // Read register: holds the last word read until the next read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= {WB_DATA_W{1'b0}};
        end else if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/team_06_wb_sram_responder.sv
// Wishbone classic subordinate backed by a word SRAM, with programmable wait states
// and a one-cycle turnaround that swallows the manager's late strobe drop.
module team_06_wb_sram_responder
    import team_06_wb_pkg::*;
#(
    parameter logic [WB_ADDR_W-1:0] BASE_ADDR   = WB_DEFAULT_BASE,
    parameter int                   DEPTH_WORDS = 1024,
    parameter int                   WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cyc_i,
    input  logic                 stb_i,
    input  logic                 we_i,
    input  logic [WB_ADDR_W-1:0] adr_i,
    input  logic [WB_SEL_W-1:0]  sel_i,
    input  logic [WB_DATA_W-1:0] dat_i,
    output logic [WB_DATA_W-1:0] dat_o,
    output logic                 ack_o,
    output logic                 err_o
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
    localparam logic [3:0] WS_LOAD   = ZERO_WAIT ? 4'd0 : 4'(WAIT_STATES - 1);

    wb_resp_state_t       state_q;
    logic [3:0]           cnt_q;
    logic                 we_q;
    logic                 bad_q;
    logic                 ack_q;
    logic                 err_q;
    logic [WB_SEL_W-1:0]  sel_q;
    logic [WB_DATA_W-1:0] dat_q;
    logic [IDX_W-1:0]     idx_q;

    logic                 req_d;
    logic [WB_ADDR_W-1:0] off_d;
    logic                 bad_d;
    logic [IDX_W-1:0]     idx_d;
    logic                 mem_we_d;
    logic                 mem_re_d;
    logic [IDX_W-1:0]     mem_idx_d;
    logic [WB_SEL_W-1:0]  mem_sel_d;
    logic [WB_DATA_W-1:0] mem_dat_d;

    assign req_d = cyc_i & stb_i;

    // Address decode; addresses below the base wrap to huge offsets and fail the range test.
    always_comb begin
        off_d = adr_i - BASE_ADDR;
        if ((off_d[1:0] != 2'b00) || ({2'b00, off_d[WB_ADDR_W-1:2]} >= 32'(DEPTH_WORDS))) begin
            bad_d = 1'b1;
        end else begin
            bad_d = 1'b0;
        end
        idx_d = off_d[IDX_W+1:2];
    end

    // Memory access fires on the edge that enters RESP; zero-wait uses the live bus fields.
    always_comb begin
        mem_we_d  = 1'b0;
        mem_re_d  = 1'b0;
        mem_idx_d = idx_q;
        mem_sel_d = sel_q;
        mem_dat_d = dat_q;
        case (state_q)
            IDLE: begin
                if (ZERO_WAIT && req_d && !bad_d) begin
                    mem_we_d  = we_i;
                    mem_re_d  = ~we_i;
                    mem_idx_d = idx_d;
                    mem_sel_d = sel_i;
                    mem_dat_d = dat_i;
                end else begin
                    mem_we_d = 1'b0;
                    mem_re_d = 1'b0;
                end
            end
            WAIT: begin
                if (req_d && (cnt_q == 4'd0) && !bad_q) begin
                    mem_we_d = we_q;
                    mem_re_d = ~we_q;
                end else begin
                    mem_we_d = 1'b0;
                    mem_re_d = 1'b0;
                end
            end
            default: begin
                mem_we_d = 1'b0;
                mem_re_d = 1'b0;
            end
        endcase
    end

    // Responder FSM with registered ack/err.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            sel_q   <= {WB_SEL_W{1'b0}};
            dat_q   <= {WB_DATA_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_d) begin
                        we_q  <= we_i;
                        bad_q <= bad_d;
                        sel_q <= sel_i;
                        dat_q <= dat_i;
                        idx_q <= idx_d;
                        if (ZERO_WAIT) begin
                            state_q <= RESP;
                            ack_q   <= ~bad_d;
                            err_q   <= bad_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= WS_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (!req_d) begin
                        state_q <= IDLE;
                        cnt_q   <= 4'd0;
                    end else if (cnt_q == 4'd0) begin
                        state_q <= RESP;
                        ack_q   <= ~bad_q;
                        err_q   <= bad_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESP: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= TURN;
                end
                TURN: begin
                    state_q <= IDLE;
                end
                default: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    team_06_wb_mem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .idx_i  (mem_idx_d),
        .we_i   (mem_we_d & rst_n),
        .re_i   (mem_re_d & rst_n),
        .sel_i  (mem_sel_d),
        .wdata_i(mem_dat_d),
        .rdata_o(dat_o)
    );

    assign ack_o = ack_q;
    assign err_o = err_q;

endmodule
